// File: rtl/calc_core.sv
// calc_core: assembles decimal operands from keyb_iface events and evaluates +, -, * (iterative shift-add).
// Build option: define CALC_SAT_EN to saturate overflowing results; otherwise results wrap modulo 2^W.
module calc_core #(
    parameter int W          = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         press,
    input  logic         is_num,
    input  logic         is_op,
    input  logic         is_eq,
    input  logic [3:0]   num_val,
    input  logic [1:0]   op_val,
    output logic [W-1:0] disp,
    output logic         busy,
    output logic         ovf,
    output logic         key_drop
);

    localparam int CW  = $clog2(MAX_DIGITS + 1);
    localparam int MCW = $clog2(W) + 1;

    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [2:0] K_NUM = 3'b100;
    localparam logic [2:0] K_OP  = 3'b010;
    localparam logic [2:0] K_EQ  = 3'b001;

    localparam logic [2*W-1:0] HALF = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};

`ifdef CALC_SAT_EN
    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
    logic res_neg;
`endif

    typedef enum logic [2:0] {
        ENTRY_A,
        OP_WAIT,
        ENTRY_B,
        EXEC,
        RESULT
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q, b_q, res_q, disp_q;
    logic [1:0]     op_q, pend_op_q;
    logic           to_result_q;
    logic [CW-1:0]  dcnt_q;
    logic           buf_valid_q;
    logic [2:0]     buf_kind_q;
    logic [3:0]     buf_nv_q;
    logic [1:0]     buf_ov_q;
    logic [2*W-1:0] mcand_q, prod_q;
    logic [W-1:0]   mplier_q;
    logic [MCW-1:0] mcnt_q;
    logic           busy_q, ovf_q, drop_q;

    logic [2:0]     live_kind;
    logic           live_valid, use_buf, ev_valid;
    logic [2:0]     ev_kind;
    logic [3:0]     ev_nv;
    logic [1:0]     ev_ov;
    logic           ev_num, ev_op, ev_eq, ev_clr;
    logic [W-1:0]   nv_ext, acc_a_d, acc_b_d, mag_a_d, mag_b_d;
    logic           digit_ok;
    logic [W:0]     a_ext, b_ext, sum_ext;
    logic [2*W-1:0] prod_d;
    logic [W-1:0]   prod_lo, wrap_res;
    logic           is_mul, mul_neg, mul_ovf, res_ovf_d, mul_done;
    logic [W-1:0]   exec_res_d;

    // A buffered event always takes priority once EXEC is over, so keys stay in order.
    always_comb begin
        live_kind  = {is_num, is_op, is_eq};
        live_valid = press
                     && (live_kind == K_NUM || live_kind == K_OP || live_kind == K_EQ)
                     && !(is_num && num_val > 4'd9);
        use_buf    = buf_valid_q && (state_q != EXEC);
        ev_valid   = use_buf || (live_valid && !buf_valid_q && (state_q != EXEC));
        ev_kind    = use_buf ? buf_kind_q : live_kind;
        ev_nv      = use_buf ? buf_nv_q   : num_val;
        ev_ov      = use_buf ? buf_ov_q   : op_val;
        ev_num     = ev_valid && (ev_kind == K_NUM);
        ev_op      = ev_valid && (ev_kind == K_OP);
        ev_eq      = ev_valid && (ev_kind == K_EQ);
        ev_clr     = ev_op && (ev_ov == OP_CLR);

        nv_ext   = {{(W-4){1'b0}}, ev_nv};
        acc_a_d  = (a_q << 3) + (a_q << 1) + nv_ext;
        acc_b_d  = (b_q << 3) + (b_q << 1) + nv_ext;
        digit_ok = dcnt_q < CW'(MAX_DIGITS);
        mag_a_d  = a_q[W-1] ? -a_q : a_q;
        mag_b_d  = b_q[W-1] ? -b_q : b_q;
    end

    // One extra sign bit catches add/sub overflow; the multiply keeps the full 2W-bit magnitude.
    always_comb begin
        is_mul    = (op_q == OP_MUL);
        a_ext     = {a_q[W-1], a_q};
        b_ext     = {b_q[W-1], b_q};
        sum_ext   = (op_q == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
        prod_d    = prod_q + (mplier_q[0] ? mcand_q : '0);
        prod_lo   = prod_d[W-1:0];
        mul_neg   = a_q[W-1] ^ b_q[W-1];
        mul_ovf   = mul_neg ? (prod_d > HALF) : (prod_d >= HALF);
        res_ovf_d = is_mul ? mul_ovf : (sum_ext[W] ^ sum_ext[W-1]);
        if (is_mul)
            wrap_res = mul_neg ? -prod_lo : prod_lo;
        else
            wrap_res = sum_ext[W-1:0];
`ifdef CALC_SAT_EN
        res_neg    = is_mul ? mul_neg : sum_ext[W];
        exec_res_d = !res_ovf_d ? wrap_res : (res_neg ? SAT_MIN : SAT_MAX);
`else
        exec_res_d = wrap_res;
`endif
        mul_done  = !is_mul || (mcnt_q == MCW'(W - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ENTRY_A;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            op_q        <= '0;
            pend_op_q   <= '0;
            to_result_q <= 1'b0;
            dcnt_q      <= '0;
            buf_valid_q <= 1'b0;
            buf_kind_q  <= '0;
            buf_nv_q    <= '0;
            buf_ov_q    <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            prod_q      <= '0;
            mcnt_q      <= '0;
            disp_q      <= '0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            if (state_q == EXEC) begin
                if (live_valid) begin
                    if (buf_valid_q) begin
                        drop_q <= 1'b1;
                    end else begin
                        buf_valid_q <= 1'b1;
                        buf_kind_q  <= live_kind;
                        buf_nv_q    <= num_val;
                        buf_ov_q    <= op_val;
                    end
                end
            end else if (buf_valid_q) begin
                // The slot frees up as it replays, so a key arriving now takes its place.
                buf_valid_q <= live_valid;
                if (live_valid) begin
                    buf_kind_q <= live_kind;
                    buf_nv_q   <= num_val;
                    buf_ov_q   <= op_val;
                end
            end

            unique case (state_q)
                EXEC: begin
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    prod_q   <= prod_d;
                    mcnt_q   <= mcnt_q + MCW'(1);
                    if (mul_done) begin
                        res_q  <= exec_res_d;
                        disp_q <= exec_res_d;
                        ovf_q  <= ovf_q | res_ovf_d;
                        busy_q <= 1'b0;
                        if (to_result_q) begin
                            state_q <= RESULT;
                        end else begin
                            a_q     <= exec_res_d;
                            op_q    <= pend_op_q;
                            state_q <= OP_WAIT;
                        end
                    end
                end
                default: begin
                    if (ev_clr) begin
                        state_q     <= ENTRY_A;
                        a_q         <= '0;
                        b_q         <= '0;
                        res_q       <= '0;
                        op_q        <= '0;
                        dcnt_q      <= '0;
                        buf_valid_q <= 1'b0;
                        disp_q      <= '0;
                        ovf_q       <= 1'b0;
                    end else begin
                        unique case (state_q)
                            ENTRY_A: begin
                                if (ev_num && digit_ok) begin
                                    a_q    <= acc_a_d;
                                    dcnt_q <= dcnt_q + CW'(1);
                                    disp_q <= acc_a_d;
                                end else if (ev_op) begin
                                    op_q    <= ev_ov;
                                    state_q <= OP_WAIT;
                                    disp_q  <= a_q;
                                end
                            end
                            OP_WAIT: begin
                                if (ev_num) begin
                                    b_q     <= nv_ext;
                                    dcnt_q  <= CW'(1);
                                    state_q <= ENTRY_B;
                                    disp_q  <= nv_ext;
                                end else if (ev_op) begin
                                    op_q <= ev_ov;
                                end
                            end
                            ENTRY_B: begin
                                if (ev_num && digit_ok) begin
                                    b_q    <= acc_b_d;
                                    dcnt_q <= dcnt_q + CW'(1);
                                    disp_q <= acc_b_d;
                                end else if (ev_op || ev_eq) begin
                                    state_q     <= EXEC;
                                    busy_q      <= 1'b1;
                                    pend_op_q   <= ev_ov;
                                    to_result_q <= ev_eq;
                                    mcand_q     <= {{W{1'b0}}, mag_a_d};
                                    mplier_q    <= mag_b_d;
                                    prod_q      <= '0;
                                    mcnt_q      <= '0;
                                end
                            end
                            RESULT: begin
                                if (ev_num) begin
                                    a_q     <= nv_ext;
                                    dcnt_q  <= CW'(1);
                                    ovf_q   <= 1'b0;
                                    state_q <= ENTRY_A;
                                    disp_q  <= nv_ext;
                                end else if (ev_op) begin
                                    a_q     <= res_q;
                                    op_q    <= ev_ov;
                                    state_q <= OP_WAIT;
                                    disp_q  <= res_q;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

    assign disp     = disp_q;
    assign busy     = busy_q;
    assign ovf      = ovf_q;
    assign key_drop = drop_q;

endmodule
